// File: rtl/prng_lcg_idx.sv
// LCG index generator: uniform indices in [0, bound) with rejection sampling.
// Ports: clk, rst_b, start cmd, seed, bound, out_* handshake, state, busy, rej_cnt.
module prng_lcg_idx #(
  parameter int          W     = 64,
  parameter logic [63:0] A     = 64'd6364136223846793005,
  parameter logic [63:0] C     = 64'd1442695040888963407,
  parameter int          IDX_W = 15,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [1:0]       start,
  input  logic [W-1:0]     prng_t_dat,
  input  logic [IDX_W-1:0] bound,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_dat,
  output logic [W-1:0]     prng_r_dat,
  output logic             busy,
  output logic [CNT_W-1:0] rej_cnt
);

  localparam logic [W-1:0] AK = W'(A);
  localparam logic [W-1:0] CK = W'(C);
  localparam logic [1:0]   RUN = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    HOLD = 2'd2
  } st_t;

  st_t              st, st_n;
  logic [W-1:0]     state, state_n;
  logic             vld_n;
  logic [IDX_W-1:0] dat_n;
  logic [CNT_W-1:0] rej_n;
  logic [W-1:0]     nxt;
  logic [IDX_W-1:0] cand;
  logic             acc;

  assign nxt  = AK * state + CK;
  assign cand = nxt[W-1 -: IDX_W];
  // bound of zero encodes the full 2^IDX_W range
  assign acc  = (bound == '0) || (cand < bound);

  always_comb begin
    st_n    = st;
    state_n = state;
    vld_n   = out_valid;
    dat_n   = out_dat;
    rej_n   = rej_cnt;
    if (start[1]) begin
      // seed overrides any state, dropping a pending index
      state_n = prng_t_dat;
      vld_n   = 1'b0;
      rej_n   = '0;
      st_n    = IDLE;
    end else begin
      unique case (st)
        IDLE: begin
          if (start == RUN) st_n = STEP;
        end
        STEP: begin
          if (start != RUN) begin
            st_n = IDLE;
          end else begin
            state_n = nxt;
            if (acc) begin
              dat_n = cand;
              vld_n = 1'b1;
              st_n  = HOLD;
            end else if (rej_cnt != '1) begin
              rej_n = rej_cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            vld_n = 1'b0;
            st_n  = (start == RUN) ? STEP : IDLE;
          end
        end
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      st        <= IDLE;
      state     <= '0;
      out_valid <= 1'b0;
      out_dat   <= '0;
      rej_cnt   <= '0;
    end else begin
      st        <= st_n;
      state     <= state_n;
      out_valid <= vld_n;
      out_dat   <= dat_n;
      rej_cnt   <= rej_n;
    end
  end

  assign prng_r_dat = state;
  assign busy       = (st != IDLE);

endmodule

// File: tb/tb_prng_lcg_idx.sv
// Directed bench for prng_lcg_idx against a software LCG model.
// Second instance uses CNT_W=4 to reach rejection saturation quickly.
module tb_prng_lcg_idx;

  localparam logic [63:0] MA = 64'd6364136223846793005;
  localparam logic [63:0] MC = 64'd1442695040888963407;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [1:0]  start = 2'b00;
  logic [63:0] seed = '0;
  logic [14:0] bound = '0;
  logic [14:0] bound2 = 15'd1;
  logic        out_ready = 1'b0;

  logic        out_valid, out_valid2;
  logic [14:0] out_dat, out_dat2;
  logic [63:0] prng_r_dat, prng_r_dat2;
  logic        busy, busy2;
  logic [15:0] rej_cnt;
  logic [3:0]  rej_cnt2;

  int checks = 0;
  int errors = 0;

  logic [63:0] ms;
  int          mrej;

  always #5 clk = ~clk;

  prng_lcg_idx dut (
    .clk(clk), .rst_b(rst_b), .start(start),
    .prng_t_dat(seed), .bound(bound), .out_ready(out_ready),
    .out_valid(out_valid), .out_dat(out_dat),
    .prng_r_dat(prng_r_dat), .busy(busy), .rej_cnt(rej_cnt)
  );

  prng_lcg_idx #(.CNT_W(4)) dut2 (
    .clk(clk), .rst_b(rst_b), .start(start),
    .prng_t_dat(seed), .bound(bound2), .out_ready(out_ready),
    .out_valid(out_valid2), .out_dat(out_dat2),
    .prng_r_dat(prng_r_dat2), .busy(busy2), .rej_cnt(rej_cnt2)
  );

  function automatic logic [63:0] lcg(input logic [63:0] s);
    return s * MA + MC;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // advance the model to its next accepted index, counting rejects
  task automatic next_acc(input logic [14:0] b);
    logic [14:0] c;
    for (int i = 0; i < 100000; i++) begin
      ms = lcg(ms);
      c  = ms[63:49];
      if (b == 15'd0 || c < b) break;
      mrej++;
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    chk(tag, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic do_seed(input logic [63:0] s);
    start = 2'b10;
    seed  = s;
    tick();
    start = 2'b00;
    ms    = s;
    mrej  = 0;
  endtask

  initial begin
    int steps;
    int accs;
    logic pre;

    // reset
    repeat (2) tick();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_dat", {49'd0, out_dat}, 64'd0);
    chk("rst_state", prng_r_dat, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rej", {48'd0, rej_cnt}, 64'd0);
    rst_b = 1'b1;
    tick();

    // seed 0, bound 0: first index is 2562
    do_seed(64'd0);
    bound     = 15'd0;
    out_ready = 1'b0;
    start     = 2'b01;
    tick();
    chk("idle_nostep", prng_r_dat, 64'd0);
    chk("step_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("t1_state", prng_r_dat, 64'h14057B7EF767814F);
    chk("t1_dat", {49'd0, out_dat}, 64'd2562);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);
    chk("t1_rej", {48'd0, rej_cnt}, 64'd0);

    // seed 0, bound 2562: first candidate rejected
    do_seed(64'd0);
    bound = 15'd2562;
    start = 2'b01;
    out_ready = 1'b0;
    next_acc(bound);
    wait_valid("t2_wait", 200);
    chk("t2_rej_min", {63'd0, (rej_cnt >= 16'd1)}, 64'd1);
    chk("t2_rej", {48'd0, rej_cnt}, 64'(mrej));
    chk("t2_dat", {49'd0, out_dat}, {49'd0, ms[63:49]});
    chk("t2_state", prng_r_dat, ms);

    // backpressure: hold for 10 cycles
    do_seed(64'd0);
    bound = 15'd2563;
    start = 2'b01;
    out_ready = 1'b0;
    wait_valid("t3_wait", 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold_v", {63'd0, out_valid}, 64'd1);
      chk("t3_hold_d", {49'd0, out_dat}, 64'd2562);
      chk("t3_hold_s", prng_r_dat, 64'h14057B7EF767814F);
    end
    out_ready = 1'b1;
    tick();
    chk("t3_drop", {63'd0, out_valid}, 64'd0);
    chk("t3_busy", {63'd0, busy}, 64'd1);
    tick();
    chk("t3_resume", prng_r_dat, lcg(64'h14057B7EF767814F));

    // long run, seed 123, bound 12323
    do_seed(64'd123);
    bound = 15'd12323;
    out_ready = 1'b1;
    start = 2'b01;
    steps = 0;
    accs  = 0;
    for (int i = 0; i < 1000; i++) begin
      pre = busy && !out_valid;
      tick();
      if (pre) steps++;
      if (out_valid) begin
        next_acc(bound);
        accs++;
        chk("t4_lt", {63'd0, (out_dat < 15'd12323)}, 64'd1);
        chk("t4_dat", {49'd0, out_dat}, {49'd0, ms[63:49]});
      end
    end
    chk("t4_count", 64'(accs) + {48'd0, rej_cnt}, 64'(steps));
    chk("t4_some", {63'd0, (accs > 100)}, 64'd1);

    // seed during HOLD
    out_ready = 1'b0;
    wait_valid("t5_wait", 50);
    do_seed(64'd321);
    chk("t5_valid", {63'd0, out_valid}, 64'd0);
    chk("t5_state", prng_r_dat, 64'd321);
    chk("t5_rej", {48'd0, rej_cnt}, 64'd0);
    chk("t5_busy", {63'd0, busy}, 64'd0);
    bound = 15'd0;
    out_ready = 1'b1;
    start = 2'b01;
    for (int k = 0; k < 3; k++) begin
      next_acc(bound);
      wait_valid("t5_run_wait", 20);
      chk("t5_run_dat", {49'd0, out_dat}, {49'd0, ms[63:49]});
      chk("t5_run_st", prng_r_dat, ms);
      tick();
    end

    // saturation and async reset mid-STEP
    do_seed(64'd0);
    bound = 15'd1;
    start = 2'b01;
    repeat (25) tick();
    chk("sat_rej2", {60'd0, rej_cnt2}, 64'd15);
    chk("sat_valid2", {63'd0, out_valid2}, 64'd0);
    chk("sat_busy", {63'd0, busy}, 64'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("arst_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_state", prng_r_dat, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_rej", {48'd0, rej_cnt}, 64'd0);
    chk("arst_rej2", {60'd0, rej_cnt2}, 64'd0);
    chk("arst_dat", {49'd0, out_dat}, 64'd0);
    start = 2'b00;
    tick();
    rst_b = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
